gate_response_checker: RTL

- Self-checking response monitor for the two-input logic_gates block. It is the receive end of the stimulus interface.
- Each cycle it captures an applied (a, b) vector together with the seven gate outputs and computes the expected values. It compares them, then accumulates per-gate sticky error flags, error and vector counts, and a first-failure snapshot.
- It sits beside the gate unit in self-test builds. After a programmed number of vectors it reports a single pass/fail verdict.

---
 rtl/gate_response_checker.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/gate_response_checker.sv
// gate_response_checker
//
// Receive-side response monitor for the two-input logic_gates block. Each
// accepted (a, b) vector is checked against the seven gate outputs two
// cycles later. Results are folded into sticky per-gate error flags, a
// saturating error counter and a snapshot of the first failing vector.
// After NUM_VECTORS vectors the pipeline drains and a pass/fail verdict is
// held until the next start.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      one-cycle pulse; begins or restarts a run (highest priority)
//   vec_valid  a, b, resp valid this cycle (only honoured in RUN)
//   a, b       applied operands
//   resp[6:0]  observed outputs: and, or, nand, nor, xor, xnor, not(a)
//   busy       high in RUN and DRAIN
//   chk_valid  one-cycle strobe, comparison result presented
//   mismatch   with chk_valid: some bit of resp was wrong
//   err_mask   sticky per-gate failure flags for this run
//   err_count  mismatching vectors, saturating at all-ones
//   vec_count  vectors accepted this run
//   fail_snap  {a, b, resp} of the first mismatching vector
//   done       verdict valid (level)
//   pass       with done: no mismatches this run

module gate_response_checker #(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             a,
  input  logic             b,
  input  logic [6:0]       resp,
  output logic             busy,
  output logic             chk_valid,
  output logic             mismatch,
  output logic [6:0]       err_mask,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [8:0]       fail_snap,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t state, state_next;

  // Stage 1: captured vector and its observed response.
  logic       s1_valid;
  logic       s1_a;
  logic       s1_b;
  logic [6:0] s1_resp;

  // Stage 2: presented comparison result.
  logic       s2_valid;
  logic       s2_mismatch;

  logic       capture;
  logic [6:0] s1_exp;
  logic [6:0] s1_diff;
  logic       s1_mism;

  function automatic logic [6:0] expected_resp(input logic ia, input logic ib);
    return {~ia, ~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ia | ib, ia & ib};
  endfunction

  // A vector coincident with start belongs to neither the old nor the new
  // run, so it is dropped.
  assign capture = (state == RUN) && vec_valid && !start;

  assign s1_exp  = expected_resp(s1_a, s1_b);
  assign s1_diff = s1_resp ^ s1_exp;
  assign s1_mism = |s1_diff;

  // Next-state logic. DRAIN only needs stage 1 empty: whatever sits in
  // stage 2 has already been accumulated, so the verdict is final on the
  // same edge the last strobe retires.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUN;
    end else begin
      unique case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (capture && (vec_count == LAST_VEC)) state_next = DRAIN;
        DRAIN:   if (!s1_valid) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      s1_valid    <= 1'b0;
      s1_a        <= 1'b0;
      s1_b        <= 1'b0;
      s1_resp     <= '0;
      s2_valid    <= 1'b0;
      s2_mismatch <= 1'b0;
      err_mask    <= '0;
      err_count   <= '0;
      vec_count   <= '0;
      fail_snap   <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        // Fresh run: anything in flight is discarded without accumulating.
        s1_valid    <= 1'b0;
        s2_valid    <= 1'b0;
        s2_mismatch <= 1'b0;
        err_mask    <= '0;
        err_count   <= '0;
        vec_count   <= '0;
        fail_snap   <= '0;
      end else begin
        s1_valid <= capture;
        if (capture) begin
          s1_a      <= a;
          s1_b      <= b;
          s1_resp   <= resp;
          vec_count <= vec_count + 1'b1;
        end

        s2_valid    <= s1_valid;
        s2_mismatch <= s1_valid & s1_mism;

        // Accumulate on the edge the result enters stage 2, while stage 1
        // still holds the vector that produced it.
        if (s1_valid) begin
          err_mask <= err_mask | s1_diff;
          if (s1_mism) begin
            if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
            if (err_count == '0) fail_snap <= {s1_a, s1_b, s1_resp};
          end
        end
      end
    end
  end

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0);
  assign chk_valid = s2_valid;
  assign mismatch  = s2_mismatch;

endmodule
